// File: rtl/cas_pkg.sv
// Shared types and default timing constants for the CoCo cassette FSK playback stage.
package cas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_END   = 3'd4
  } cas_state_t;

  localparam int CAS_ADDR_W = 25;
  localparam int CAS_RD_LAT = 4;
  localparam int CAS_HALF0  = 373;  // 1200 Hz half-cycle at 0.895 MHz Q
  localparam int CAS_HALF1  = 186;  // 2400 Hz half-cycle

endpackage

// File: rtl/cas_fsk_gen.sv
// One-bit FSK cycle generator: a high half then a low half, each HALFx advance ticks long.
// A start pulse re-arms immediately, so back-to-back bits have no gap.
module cas_fsk_gen
  import cas_pkg::*;
#(
  parameter int HALF0 = CAS_HALF0,
  parameter int HALF1 = CAS_HALF1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic adv_i,
  input  logic start_i,
  input  logic bit_i,
  output logic data_o,
  output logic bit_done_o
);

  localparam int CNT_W = $clog2(HALF0 + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  logic             busy_q, busy_d;
  logic             phase_q, phase_d;
  logic             bit_q, bit_d;
  logic             data_q, data_d;
  logic             half_end;

  assign lim        = bit_q ? CNT_W'(HALF1 - 1) : CNT_W'(HALF0 - 1);
  assign half_end   = busy_q & adv_i & (cnt_q == lim);
  assign bit_done_o = half_end & phase_q;
  assign data_o     = data_q;

  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    data_d  = data_q;
    if (clr_i) begin
      cnt_d   = '0;
      busy_d  = 1'b0;
      phase_d = 1'b0;
      data_d  = 1'b0;
    end else if (start_i) begin
      cnt_d   = '0;
      busy_d  = 1'b1;
      phase_d = 1'b0;
      bit_d   = bit_i;
      data_d  = 1'b1;
    end else if (busy_q && adv_i) begin
      if (half_end) begin
        cnt_d  = '0;
        data_d = 1'b0;
        if (!phase_q) phase_d = 1'b1;
        else          busy_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
      bit_q   <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/cas_fsk_player.sv
// CAS tape playback: fetches image bytes from SDRAM and plays them LSB-first as CoCo FSK audio.
// SDRAM read: sdram_rd is a 1-cycle strobe with sdram_addr stable; sdram_data is valid exactly RD_LAT cycles later.
module cas_fsk_player
  import cas_pkg::*;
#(
  parameter int ADDR_W = CAS_ADDR_W,
  parameter int RD_LAT = CAS_RD_LAT,
  parameter int HALF0  = CAS_HALF0,
  parameter int HALF1  = CAS_HALF1
) (
  input  logic              CLK50MHZ,
  input  logic              COCO_RESET_N,
  input  logic              Q,
  input  logic              en,
  input  logic              rewind,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rd,
  input  logic [7:0]        sdram_data,
  output logic              data,
  output logic              playing,
  output logic              eot
);

  localparam int LAT_W = $clog2(RD_LAT + 1);

  cas_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              rd_q, rd_d;
  logic [7:0]        sr_q, sr_d, pf_q, pf_d;
  logic              sr_valid_q, sr_valid_d;
  logic              pf_valid_q, pf_valid_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [2:0]        q_sync_q;
  logic              q_tick, gen_start, gen_bit, bit_done, more;

  // q_sync_q[1:0] is the synchroniser; q_sync_q[2] only remembers the previous level.
  assign q_tick = q_sync_q[1] & ~q_sync_q[2];
  assign more   = addr_q < tape_len;

  cas_fsk_gen #(.HALF0(HALF0), .HALF1(HALF1)) u_gen (
    .clk_i      (CLK50MHZ),
    .rst_ni     (COCO_RESET_N),
    .clr_i      (rewind),
    .adv_i      (q_tick & en),
    .start_i    (gen_start),
    .bit_i      (gen_bit),
    .data_o     (data),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lat_d      = lat_q;
    rd_d       = 1'b0;
    sr_d       = sr_q;
    sr_valid_d = sr_valid_q;
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    bitcnt_d   = bitcnt_q;
    gen_start  = 1'b0;
    gen_bit    = 1'b0;

    // Bit boundaries are handled in every state: playback overlaps the prefetch.
    if (bit_done) begin
      if (bitcnt_q != 3'd7) begin
        sr_d      = {1'b0, sr_q[7:1]};
        bitcnt_d  = bitcnt_q + 3'd1;
        gen_start = 1'b1;
        gen_bit   = sr_q[1];
      end else if (pf_valid_q) begin
        sr_d       = pf_q;
        pf_valid_d = 1'b0;
        bitcnt_d   = 3'd0;
        gen_start  = 1'b1;
        gen_bit    = pf_q[0];
      end else begin
        sr_valid_d = 1'b0;
        bitcnt_d   = 3'd0;
      end
    end

    case (state_q)
      ST_IDLE: if (en && tape_len != '0) state_d = ST_FETCH;
      ST_FETCH: begin
        if (en) begin
          rd_d    = 1'b1;
          lat_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The read completes even with the motor off; it just cannot start a bit then.
        lat_d = lat_q + LAT_W'(1);
        if (lat_q == LAT_W'(RD_LAT)) begin
          addr_d = addr_q + ADDR_W'(1);
          if (en && !sr_valid_d) begin
            sr_d       = sdram_data;
            sr_valid_d = 1'b1;
            bitcnt_d   = 3'd0;
            gen_start  = 1'b1;
            gen_bit    = sdram_data[0];
            state_d    = (addr_d < tape_len) ? ST_FETCH : ST_PLAY;
          end else begin
            pf_d       = sdram_data;
            pf_valid_d = 1'b1;
            state_d    = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        if (en) begin
          if (!sr_valid_q && pf_valid_q) begin
            sr_d       = pf_q;
            sr_valid_d = 1'b1;
            pf_valid_d = 1'b0;
            bitcnt_d   = 3'd0;
            gen_start  = 1'b1;
            gen_bit    = pf_q[0];
            if (more) state_d = ST_FETCH;
          end else if (bit_done && bitcnt_q == 3'd7 && pf_valid_q) begin
            if (more) state_d = ST_FETCH;
          end else if (!sr_valid_q && !pf_valid_q) begin
            state_d = more ? ST_FETCH : ST_END;
          end
        end
      end
      ST_END:  state_d = ST_END;
      default: state_d = ST_IDLE;
    endcase

    if (rewind) begin
      state_d    = ST_IDLE;
      addr_d     = '0;
      lat_d      = '0;
      rd_d       = 1'b0;
      sr_d       = '0;
      sr_valid_d = 1'b0;
      pf_valid_d = 1'b0;
      bitcnt_d   = 3'd0;
    end
  end

  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      lat_q      <= '0;
      rd_q       <= 1'b0;
      sr_q       <= '0;
      sr_valid_q <= 1'b0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
      bitcnt_q   <= 3'd0;
      q_sync_q   <= 3'b000;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lat_q      <= lat_d;
      rd_q       <= rd_d;
      sr_q       <= sr_d;
      sr_valid_q <= sr_valid_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
      bitcnt_q   <= bitcnt_d;
      q_sync_q   <= {q_sync_q[1:0], Q};
    end
  end

  assign sdram_addr = addr_q;
  assign sdram_rd   = rd_q;
  assign eot        = (state_q == ST_END);
  assign playing    = (state_q == ST_PLAY) |
                      (((state_q == ST_FETCH) | (state_q == ST_WAIT)) & sr_valid_q);

endmodule

// File: tb/tb_cas_fsk_player.sv
// Bench for cas_fsk_player: SDRAM latency model, Q tick reference, FSK cycle monitor with expected-bit queue.
module tb_cas_fsk_player;

  localparam int ADDR_W = 25;
  localparam int RD_LAT = 4;
  localparam int HALF0  = 12;
  localparam int HALF1  = 6;

  logic              CLK50MHZ = 1'b0;
  logic              COCO_RESET_N = 1'b1;
  logic              Q = 1'b0;
  logic              en = 1'b0;
  logic              rewind = 1'b0;
  logic [ADDR_W-1:0] tape_len = '0;
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_rd;
  logic [7:0]        sdram_data;
  logic              data, playing, eot;

  int total = 0;
  int bad   = 0;
  int rd_count = 0;
  logic [0:0] exp_q[$];
  logic [7:0] mem [8];
  logic [7:0] pipe [RD_LAT];

  cas_fsk_player #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .HALF0(HALF0), .HALF1(HALF1)) dut (
    .CLK50MHZ     (CLK50MHZ),
    .COCO_RESET_N (COCO_RESET_N),
    .Q            (Q),
    .en           (en),
    .rewind       (rewind),
    .tape_len     (tape_len),
    .sdram_addr   (sdram_addr),
    .sdram_rd     (sdram_rd),
    .sdram_data   (sdram_data),
    .data         (data),
    .playing      (playing),
    .eot          (eot)
  );

  // clock / Q / reference tick
  always #5 CLK50MHZ = ~CLK50MHZ;
  always #30 Q = ~Q;

  logic q1_b, q2_b, q3_b, tick_b;
  always @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      q1_b <= 1'b0; q2_b <= 1'b0; q3_b <= 1'b0;
    end else begin
      q1_b <= Q; q2_b <= q1_b; q3_b <= q2_b;
    end
  end
  assign tick_b = q2_b & ~q3_b;

  // SDRAM: data valid exactly RD_LAT cycles after the strobe, random garbage otherwise
  always @(posedge CLK50MHZ) begin
    pipe[0] <= sdram_rd ? mem[sdram_addr[2:0]] : 8'($urandom);
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign sdram_data = pipe[RD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic emit(input int hi, input int lo);
    logic [0:0] b;
    int h;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL fsk_extra: got cycle hi=%0d lo=%0d expected no more bits", hi, lo);
    end else begin
      total--;
      b = exp_q.pop_front();
      h = b ? HALF1 : HALF0;
      check("fsk_hi", 32'(hi), 32'(h));
      check("fsk_lo", 32'(lo), 32'(h));
    end
  endtask

  // monitor: measures each FSK cycle in Q ticks, checks read addresses
  logic prev_data = 1'b0, prev_eot = 1'b0, have_hi = 1'b0;
  int hi_len = 0, cnt = 0;
  logic [ADDR_W-1:0] rd_expect = '0;
  always @(negedge CLK50MHZ) begin
    if (!COCO_RESET_N || rewind) begin
      prev_data = 1'b0; prev_eot = 1'b0; have_hi = 1'b0; cnt = 0; rd_expect = '0;
    end else begin
      if (sdram_rd) begin
        rd_count++;
        check("rd_addr", 32'(sdram_addr), 32'(rd_expect));
        check("rd_in_range", 32'(sdram_addr < tape_len), 32'd1);
        rd_expect = rd_expect + ADDR_W'(1);
      end
      if (prev_data && !data) begin
        hi_len = cnt; have_hi = 1'b1; cnt = 0;
      end else if (!prev_data && data) begin
        if (have_hi) emit(hi_len, cnt);
        have_hi = 1'b0; cnt = 0;
      end
      if (eot && !prev_eot && have_hi) begin
        emit(hi_len, cnt);
        have_hi = 1'b0;
      end
      if (tick_b && en) cnt++;
      prev_data = data;
      prev_eot  = eot;
    end
  end

  // driver tasks
  task automatic clr_tape();
    en = 1'b0;
    rewind = 1'b1;
    @(posedge CLK50MHZ); #1;
    rewind = 1'b0;
    exp_q.delete();
    rd_count = 0;
  endtask

  task automatic load(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    mem[0] = b0; mem[1] = b1; mem[2] = b2;
    tape_len = ADDR_W'(n);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) exp_q.push_back(mem[i][k]);
  endtask

  task automatic wait_eot(input string name, input int budget);
    int n = 0;
    while (!eot && n < budget) begin
      @(negedge CLK50MHZ);
      n++;
    end
    check(name, 32'(eot), 32'd1);
    @(posedge CLK50MHZ); #1;
  endtask

  initial begin
    int n, guard;
    logic held;
    logic [ADDR_W-1:0] a0;

    // reset
    #2 COCO_RESET_N = 1'b0;
    #20;
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_rd", 32'(sdram_rd), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_eot", 32'(eot), 32'd0);
    @(posedge CLK50MHZ); #1 COCO_RESET_N = 1'b1;
    repeat (3) @(posedge CLK50MHZ); #1;

    // T5: no tape
    clr_tape();
    load(0, 8'h00, 8'h00, 8'h00);
    en = 1'b1;
    repeat (200) @(posedge CLK50MHZ); #1;
    check("t5_rd_count", 32'(rd_count), 32'd0);
    check("t5_data", 32'(data), 32'd0);
    check("t5_playing", 32'(playing), 32'd0);
    check("t5_eot", 32'(eot), 32'd0);

    // T1: single byte 0x55
    clr_tape();
    load(1, 8'h55, 8'h00, 8'h00);
    en = 1'b1;
    wait_eot("t1_eot", 4000);
    check("t1_rd_count", 32'(rd_count), 32'd1);
    check("t1_data", 32'(data), 32'd0);
    check("t1_playing", 32'(playing), 32'd0);
    check("t1_bits_left", 32'(exp_q.size()), 32'd0);

    // T2: three bytes, no gaps
    clr_tape();
    load(3, 8'h00, 8'hFF, 8'h3C);
    en = 1'b1;
    wait_eot("t2_eot", 8000);
    check("t2_rd_count", 32'(rd_count), 32'd3);
    check("t2_addr", 32'(sdram_addr), 32'd3);
    check("t2_bits_left", 32'(exp_q.size()), 32'd0);

    // T3: motor off mid '0' half
    clr_tape();
    load(1, 8'h00, 8'h00, 8'h00);
    en = 1'b1;
    n = 0; guard = 0;
    while (n < 5 && guard < 3000) begin
      @(negedge CLK50MHZ);
      guard++;
      if (data && tick_b && en) n++;
    end
    check("t3_reach_5", 32'(n), 32'd5);
    @(posedge CLK50MHZ); #1 en = 1'b0;
    a0 = sdram_addr;
    n = 0; guard = 0; held = 1'b1;
    while (n < 40 && guard < 1000) begin
      @(negedge CLK50MHZ);
      guard++;
      if (tick_b) n++;
      if (!data) held = 1'b0;
    end
    check("t3_data_held", 32'(held), 32'd1);
    check("t3_addr_held", 32'(sdram_addr), 32'(a0));
    check("t3_playing", 32'(playing), 32'd1);
    @(posedge CLK50MHZ); #1 en = 1'b1;
    n = 0; guard = 0;
    while (guard < 1000) begin
      @(negedge CLK50MHZ);
      guard++;
      if (!data) break;
      if (tick_b && en) n++;
    end
    check("t3_resume_ticks", 32'(n), 32'(HALF0 - 5));
    wait_eot("t3_eot", 4000);
    check("t3_bits_left", 32'(exp_q.size()), 32'd0);

    // T4: rewind while the read of byte 2 is in flight
    clr_tape();
    load(3, 8'hA5, 8'h0F, 8'h81);
    en = 1'b1;
    guard = 0; held = 1'b0;
    while (guard < 6000) begin
      @(negedge CLK50MHZ);
      guard++;
      if (sdram_rd && sdram_addr == ADDR_W'(2)) begin
        held = 1'b1;
        break;
      end
    end
    check("t4_rd2_seen", 32'(held), 32'd1);
    @(posedge CLK50MHZ); #1 rewind = 1'b1;
    exp_q.delete();
    @(posedge CLK50MHZ); #1 rewind = 1'b0;
    check("t4_addr", 32'(sdram_addr), 32'd0);
    check("t4_data", 32'(data), 32'd0);
    check("t4_eot", 32'(eot), 32'd0);
    check("t4_playing", 32'(playing), 32'd0);
    rd_count = 0;
    load(3, 8'hA5, 8'h0F, 8'h81);
    wait_eot("t4_eot_replay", 8000);
    check("t4_rd_count", 32'(rd_count), 32'd3);
    check("t4_bits_left", 32'(exp_q.size()), 32'd0);

    // T6: async reset mid-byte
    clr_tape();
    load(2, 8'h5A, 8'hC3, 8'h00);
    en = 1'b1;
    repeat (300) @(posedge CLK50MHZ);
    guard = 0;
    while (!data && guard < 1000) begin
      @(negedge CLK50MHZ);
      guard++;
    end
    @(posedge CLK50MHZ); #3;
    COCO_RESET_N = 1'b0;
    #1;
    check("t6_addr", 32'(sdram_addr), 32'd0);
    check("t6_rd", 32'(sdram_rd), 32'd0);
    check("t6_data", 32'(data), 32'd0);
    check("t6_playing", 32'(playing), 32'd0);
    check("t6_eot", 32'(eot), 32'd0);
    en = 1'b0;
    exp_q.delete();
    rd_count = 0;
    @(posedge CLK50MHZ); #1 COCO_RESET_N = 1'b1;
    repeat (100) @(posedge CLK50MHZ); #1;
    check("t6_idle_rd", 32'(rd_count), 32'd0);
    check("t6_idle_playing", 32'(playing), 32'd0);
    load(2, 8'h5A, 8'hC3, 8'h00);
    en = 1'b1;
    wait_eot("t6_eot", 6000);
    check("t6_rd_count", 32'(rd_count), 32'd2);
    check("t6_bits_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
